// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: next-PC select codes,
// reset/NOP defaults and the instruction-fetch state encoding.
package mips_pkg;

  localparam logic [1:0] ADDRSEL_PC4    = 2'b00;
  localparam logic [1:0] ADDRSEL_JUMP   = 2'b01;
  localparam logic [1:0] ADDRSEL_BRANCH = 2'b10;
  localparam logic [1:0] ADDRSEL_JR     = 2'b11;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register holding {instruction, PC+4, valid}; supports load, hold,
// and a bubble load that inserts the NOP encoding with valid cleared.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out,
  output logic        valid_out
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (load) begin
      pc4_d = pc4_in;
      if (bubble) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else begin
        instr_d = instr_in;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out = instr_q;
  assign pc4_out   = pc4_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, single-outstanding
// imem handshake with a one-word skid buffer, and the IF/ID register.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IF_write,
  input  logic        PC_write,
  input  logic        bubble,
  input  logic [1:0]  addrSel,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JrTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_instr,
  output logic [31:0] ID_pc4,
  output logic        ID_valid,
  output logic [31:0] PC
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         held_valid_q, held_valid_d;
  logic [31:0]  held_instr_q, held_instr_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic         post_rst_q, post_rst_d;

  logic         redirect;
  logic [31:0]  target;
  logic         ack_eff;
  logic         have;
  logic [31:0]  word;
  logic         ifid_load;
  logic         ifid_bubble;

  always_comb begin
    redirect = PC_write && (addrSel != ADDRSEL_PC4);
    case (addrSel)
      ADDRSEL_JUMP:   target = JumpTarget;
      ADDRSEL_BRANCH: target = BranchTarget;
      ADDRSEL_JR:     target = JrTarget;
      default:        target = pc_plus4(pc_q);
    endcase

    // The cycle right after reset never requests, so a late ack from a
    // dropped pre-reset request cannot be mistaken for fresh data.
    if (state_q == DRAIN) begin
      imem_req  = 1'b1;
      imem_addr = drain_addr_q;
    end else begin
      imem_req  = !held_valid_q && !post_rst_q;
      imem_addr = pc_q;
    end

    ack_eff = imem_ack && imem_req;
    have    = (state_q == FETCH) && (held_valid_q || ack_eff);
    word    = held_valid_q ? held_instr_q : imem_rdata;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    held_valid_d = held_valid_q;
    held_instr_d = held_instr_q;
    drain_addr_d = drain_addr_q;
    post_rst_d   = 1'b0;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;

    if (state_q == FETCH) begin
      if (redirect) begin
        pc_d         = target;
        held_valid_d = 1'b0;
        if (imem_req && !ack_eff) begin
          state_d      = DRAIN;
          drain_addr_d = pc_q;
        end
        ifid_load   = IF_write;
        ifid_bubble = 1'b1;
      end else if (have && IF_write) begin
        ifid_load   = 1'b1;
        ifid_bubble = bubble;
        if (PC_write) begin
          pc_d         = pc_plus4(pc_q);
          held_valid_d = 1'b0;
        end else if (ack_eff) begin
          held_valid_d = 1'b1;
          held_instr_d = imem_rdata;
        end
      end else if (!have) begin
        ifid_load   = IF_write;
        ifid_bubble = 1'b1;
      end else if (ack_eff) begin
        // Decode is stalled: park the returned word until IF/ID can take it.
        held_valid_d = 1'b1;
        held_instr_d = imem_rdata;
      end
    end else begin
      if (redirect) begin
        pc_d = target;
      end else begin
        ifid_load   = IF_write;
        ifid_bubble = 1'b1;
      end
      if (ack_eff) begin
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      held_valid_q <= 1'b0;
      held_instr_q <= NOP_INSTR;
      drain_addr_q <= RESET_PC;
      post_rst_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      held_valid_q <= held_valid_d;
      held_instr_q <= held_instr_d;
      drain_addr_q <= drain_addr_d;
      post_rst_q   <= post_rst_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .Clk       (Clk),
    .Rst       (Rst),
    .load      (ifid_load),
    .bubble    (ifid_bubble),
    .instr_in  (word),
    .pc4_in    (pc_plus4(pc_q)),
    .instr_out (ID_instr),
    .pc4_out   (ID_pc4),
    .valid_out (ID_valid)
  );

  assign PC = pc_q;

  // IF_write without PC_write re-presents the same instruction next cycle.
  ap_if_write_without_pc_write : assert property (
    @(posedge Clk) disable iff (Rst)
      !(IF_write && !PC_write && (addrSel == ADDRSEL_PC4)));

  ap_ack_without_req : assert property (
    @(posedge Clk) disable iff (Rst || post_rst_q)
      !(imem_ack && !imem_req));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a wait-state-configurable memory model.
module tb_if_fetch_stage;

  logic        Clk;
  logic        Rst;
  logic        IF_write;
  logic        PC_write;
  logic        bubble;
  logic [1:0]  addrSel;
  logic [31:0] JumpTarget;
  logic [31:0] BranchTarget;
  logic [31:0] JrTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ID_instr;
  logic [31:0] ID_pc4;
  logic        ID_valid;
  logic [31:0] PC;

  int   checks    = 0;
  int   errors    = 0;
  int   mem_wait  = 0;
  int   wait_cnt  = 0;
  logic force_ack = 1'b0;

  if_fetch_stage dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .IF_write     (IF_write),
    .PC_write     (PC_write),
    .bubble       (bubble),
    .addrSel      (addrSel),
    .JumpTarget   (JumpTarget),
    .BranchTarget (BranchTarget),
    .JrTarget     (JrTarget),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ID_instr     (ID_instr),
    .ID_pc4       (ID_pc4),
    .ID_valid     (ID_valid),
    .PC           (PC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory: acks once a request has been pending mem_wait cycles; data is addr^DEAD0000.
  assign imem_ack   = force_ack | (imem_req && (wait_cnt >= mem_wait));
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  always @(posedge Clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  task tick();
    @(posedge Clk);
    #1;
    $display("t=%0t pc=%h req=%b addr=%h id_instr=%h id_pc4=%h id_valid=%b",
             $time, PC, imem_req, imem_addr, ID_instr, ID_pc4, ID_valid);
  endtask

  task test_reset();
    Rst = 1'b1;
    tick();
    tick();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", PC, 32'h0); end
    checks++; if (ID_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", ID_instr, 32'h0); end
    checks++; if (ID_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h expected %h", ID_pc4, 32'h0); end
    checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ID_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    Rst = 1'b0;
    force_ack = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL post_reset_req: got %b expected 0", imem_req); end
    tick();
    force_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL late_ack_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL late_ack_addr: got %h expected %h", imem_addr, 32'h0); end
    checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL late_ack_valid: got %b expected 0", ID_valid); end
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL late_ack_pc: got %h expected %h", PC, 32'h0); end
  endtask

  task test_sequential();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'(4 * i);
      checks++; if (imem_addr !== a) begin errors++; $display("FAIL seq_addr: got %h expected %h", imem_addr, a); end
      tick();
      checks++; if (ID_instr !== (a ^ 32'hDEAD_0000)) begin errors++; $display("FAIL seq_instr: got %h expected %h", ID_instr, a ^ 32'hDEAD_0000); end
      checks++; if (ID_pc4 !== a + 32'd4) begin errors++; $display("FAIL seq_pc4: got %h expected %h", ID_pc4, a + 32'd4); end
      checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL seq_valid: got %b expected 1", ID_valid); end
      checks++; if (PC !== a + 32'd4) begin errors++; $display("FAIL seq_pc: got %h expected %h", PC, a + 32'd4); end
    end
  endtask

  task test_hazard_stall();
    IF_write = 1'b0; PC_write = 1'b0; bubble = 1'b1;
    tick();
    checks++; if (PC !== 32'h10) begin errors++; $display("FAIL hazard_pc: got %h expected %h", PC, 32'h10); end
    checks++; if (ID_instr !== 32'hDEAD_000C) begin errors++; $display("FAIL hazard_instr_hold: got %h expected %h", ID_instr, 32'hDEAD_000C); end
    checks++; if (ID_pc4 !== 32'h10) begin errors++; $display("FAIL hazard_pc4_hold: got %h expected %h", ID_pc4, 32'h10); end
    checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL hazard_valid_hold: got %b expected 1", ID_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hazard_held_req: got %b expected 0", imem_req); end
    IF_write = 1'b1; PC_write = 1'b1; bubble = 1'b0;
    tick();
    checks++; if (ID_instr !== 32'hDEAD_0010) begin errors++; $display("FAIL held_instr: got %h expected %h", ID_instr, 32'hDEAD_0010); end
    checks++; if (ID_pc4 !== 32'h14) begin errors++; $display("FAIL held_pc4: got %h expected %h", ID_pc4, 32'h14); end
    checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL held_valid: got %b expected 1", ID_valid); end
    checks++; if (PC !== 32'h14) begin errors++; $display("FAIL held_pc: got %h expected %h", PC, 32'h14); end
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL held_next_addr: got %h expected %h", imem_addr, 32'h14); end
  endtask

  task test_jump();
    tick(); tick(); tick();
    checks++; if (PC !== 32'h20) begin errors++; $display("FAIL jump_pre_pc: got %h expected %h", PC, 32'h20); end
    addrSel = 2'b01; JumpTarget = 32'h400;
    tick();
    addrSel = 2'b00;
    #1;
    checks++; if (imem_addr !== 32'h400) begin errors++; $display("FAIL jump_addr: got %h expected %h", imem_addr, 32'h400); end
    checks++; if (PC !== 32'h400) begin errors++; $display("FAIL jump_pc: got %h expected %h", PC, 32'h400); end
    checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL jump_valid: got %b expected 0", ID_valid); end
    checks++; if (ID_instr !== 32'h0) begin errors++; $display("FAIL jump_instr: got %h expected %h", ID_instr, 32'h0); end
    bubble = 1'b1;
    tick();
    bubble = 1'b0;
    checks++; if (ID_instr !== 32'h0) begin errors++; $display("FAIL bubble_instr: got %h expected %h", ID_instr, 32'h0); end
    checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b expected 0", ID_valid); end
    checks++; if (ID_pc4 !== 32'h404) begin errors++; $display("FAIL bubble_pc4: got %h expected %h", ID_pc4, 32'h404); end
    checks++; if (PC !== 32'h404) begin errors++; $display("FAIL bubble_pc: got %h expected %h", PC, 32'h404); end
    tick();
    checks++; if (ID_instr !== 32'hDEAD_0404) begin errors++; $display("FAIL post_bubble_instr: got %h expected %h", ID_instr, 32'hDEAD_0404); end
    checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL post_bubble_valid: got %b expected 1", ID_valid); end
  endtask

  task test_branch_drain();
    addrSel = 2'b01; JumpTarget = 32'h30;
    tick();
    addrSel = 2'b10; BranchTarget = 32'h80; mem_wait = 3;
    tick();
    addrSel = 2'b00;
    #1;
    checks++; if (PC !== 32'h80) begin errors++; $display("FAIL branch_pc: got %h expected %h", PC, 32'h80); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drain_req: got %b expected 1", imem_req); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_addr !== 32'h30) begin errors++; $display("FAIL drain_addr: got %h expected %h", imem_addr, 32'h30); end
      checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", ID_valid); end
      tick();
    end
    mem_wait = 0;
    #1;
    checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL branch_target_addr: got %h expected %h", imem_addr, 32'h80); end
    tick();
    checks++; if (ID_instr !== 32'hDEAD_0080) begin errors++; $display("FAIL branch_instr: got %h expected %h", ID_instr, 32'hDEAD_0080); end
    checks++; if (ID_pc4 !== 32'h84) begin errors++; $display("FAIL branch_pc4: got %h expected %h", ID_pc4, 32'h84); end
    checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL branch_valid: got %b expected 1", ID_valid); end
  endtask

  task test_mem_wait();
    mem_wait = 2;
    #1;
    checks++; if (imem_addr !== 32'h84) begin errors++; $display("FAIL wait_addr: got %h expected %h", imem_addr, 32'h84); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL wait_bubble_valid: got %b expected 0", ID_valid); end
      checks++; if (ID_instr !== 32'h0) begin errors++; $display("FAIL wait_bubble_instr: got %h expected %h", ID_instr, 32'h0); end
      checks++; if (PC !== 32'h84) begin errors++; $display("FAIL wait_pc_hold: got %h expected %h", PC, 32'h84); end
    end
    tick();
    mem_wait = 0;
    checks++; if (ID_instr !== 32'hDEAD_0084) begin errors++; $display("FAIL wait_instr: got %h expected %h", ID_instr, 32'hDEAD_0084); end
    checks++; if (ID_pc4 !== 32'h88) begin errors++; $display("FAIL wait_pc4: got %h expected %h", ID_pc4, 32'h88); end
    checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL wait_valid: got %b expected 1", ID_valid); end
    checks++; if (PC !== 32'h88) begin errors++; $display("FAIL wait_pc: got %h expected %h", PC, 32'h88); end
  endtask

  task test_reset_in_drain();
    mem_wait = 3; addrSel = 2'b11; JrTarget = 32'h200;
    tick();
    addrSel = 2'b00;
    #1;
    checks++; if (PC !== 32'h200) begin errors++; $display("FAIL jr_pc: got %h expected %h", PC, 32'h200); end
    checks++; if (imem_addr !== 32'h88) begin errors++; $display("FAIL jr_drain_addr: got %h expected %h", imem_addr, 32'h88); end
    Rst = 1'b1;
    tick();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_drain_pc: got %h expected %h", PC, 32'h0); end
    checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL rst_drain_valid: got %b expected 0", ID_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_drain_req: got %b expected 0", imem_req); end
    Rst = 1'b0; mem_wait = 0;
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL refetch_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL refetch_addr: got %h expected %h", imem_addr, 32'h0); end
    tick();
    checks++; if (ID_instr !== 32'hDEAD_0000) begin errors++; $display("FAIL refetch_instr: got %h expected %h", ID_instr, 32'hDEAD_0000); end
    checks++; if (ID_pc4 !== 32'h4) begin errors++; $display("FAIL refetch_pc4: got %h expected %h", ID_pc4, 32'h4); end
    checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL refetch_valid: got %b expected 1", ID_valid); end
    checks++; if (PC !== 32'h4) begin errors++; $display("FAIL refetch_pc: got %h expected %h", PC, 32'h4); end
  endtask

  initial begin
    Rst = 1'b1; IF_write = 1'b1; PC_write = 1'b1; bubble = 1'b0; addrSel = 2'b00;
    JumpTarget = 32'h0; BranchTarget = 32'h0; JrTarget = 32'h0;
    test_reset();
    test_sequential();
    test_hazard_stall();
    test_jump();
    test_branch_drain();
    test_mem_wait();
    test_reset_in_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
